// File: rtl/sram_arbiter_ctrl.sv
// Round-robin arbiter for two requesters sharing one 16-bit asynchronous SRAM.
// Each command runs the SRAM through SETUP, ACCESS and HOLD phases with registered pin outputs.
module sram_arbiter_ctrl #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic        a_req_write,
    input  logic [15:0] a_req_addr,
    input  logic [15:0] a_req_wdata,
    input  logic [1:0]  a_req_be,
    output logic        a_rsp_valid,
    output logic [15:0] a_rsp_rdata,

    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic        b_req_write,
    input  logic [15:0] b_req_addr,
    input  logic [15:0] b_req_wdata,
    input  logic [1:0]  b_req_be,
    output logic        b_rsp_valid,
    output logic [15:0] b_rsp_rdata,

    output logic [15:0] io_address,
    input  logic [15:0] io_data_read,
    output logic [15:0] io_data_write,
    output logic        io_data_writeEnable,
    output logic        io_ce,
    output logic        io_we,
    output logic        io_oe,
    output logic        io_ub,
    output logic        io_lb
);

    localparam logic [3:0] SetupLoad  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] AccessLoad = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] HoldLoad   = (HOLD_CYCLES == 0) ? 4'd0 : 4'(HOLD_CYCLES - 1);
    localparam bit         HasHold    = (HOLD_CYCLES != 0);

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StDone} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        last_grant_b_q;
    logic        port_b_q;
    logic        write_q;
    logic [15:0] rdata_q;

    logic        grant_a, grant_b, accept;
    logic        sel_write;
    logic [15:0] sel_addr, sel_wdata;
    logic [1:0]  sel_be;
    logic        phase_end, enter_done, done_port_b, done_load_rdata;
    logic [15:0] done_rdata;

    always_comb begin
        grant_a     = a_req_valid && (!b_req_valid || last_grant_b_q);
        grant_b     = b_req_valid && (!a_req_valid || !last_grant_b_q);
        a_req_ready = (state_q == StIdle) && grant_a;
        b_req_ready = (state_q == StIdle) && grant_b;
        accept      = a_req_ready || b_req_ready;

        sel_write = b_req_ready ? b_req_write : a_req_write;
        sel_addr  = b_req_ready ? b_req_addr  : a_req_addr;
        sel_wdata = b_req_ready ? b_req_wdata : a_req_wdata;
        sel_be    = b_req_ready ? b_req_be    : a_req_be;

        phase_end = (cnt_q == 4'd0);

        // A byte-enable of 00 skips the SRAM cycle entirely and completes with zero data.
        enter_done      = 1'b0;
        done_rdata      = rdata_q;
        done_load_rdata = !write_q;
        done_port_b     = port_b_q;
        case (state_q)
            StIdle: begin
                enter_done      = accept && (sel_be == 2'b00);
                done_rdata      = 16'h0000;
                done_load_rdata = 1'b1;
                done_port_b     = b_req_ready;
            end
            StAccess: begin
                enter_done = phase_end && !HasHold;
                done_rdata = io_data_read;
            end
            StHold:  enter_done = phase_end;
            default: enter_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= StIdle;
            cnt_q               <= 4'd0;
            last_grant_b_q      <= 1'b1;
            port_b_q            <= 1'b0;
            write_q             <= 1'b0;
            rdata_q             <= 16'h0000;
            a_rsp_valid         <= 1'b0;
            a_rsp_rdata         <= 16'h0000;
            b_rsp_valid         <= 1'b0;
            b_rsp_rdata         <= 16'h0000;
            io_address          <= 16'h0000;
            io_data_write       <= 16'h0000;
            io_data_writeEnable <= 1'b0;
            io_ce               <= 1'b1;
            io_we               <= 1'b1;
            io_oe               <= 1'b1;
            io_ub               <= 1'b1;
            io_lb               <= 1'b1;
        end else begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        last_grant_b_q <= b_req_ready;
                        port_b_q       <= b_req_ready;
                        write_q        <= sel_write;
                        if (sel_be == 2'b00) begin
                            state_q <= StDone;
                        end else begin
                            state_q             <= StSetup;
                            cnt_q               <= SetupLoad;
                            io_address          <= sel_addr;
                            io_ce               <= 1'b0;
                            io_ub               <= ~sel_be[1];
                            io_lb               <= ~sel_be[0];
                            io_data_writeEnable <= sel_write;
                            if (sel_write) begin
                                io_data_write <= sel_wdata;
                            end
                        end
                    end
                end
                StSetup: begin
                    if (phase_end) begin
                        state_q <= StAccess;
                        cnt_q   <= AccessLoad;
                        if (write_q) begin
                            io_we <= 1'b0;
                        end else begin
                            io_oe <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAccess: begin
                    if (phase_end) begin
                        io_we <= 1'b1;
                        io_oe <= 1'b1;
                        if (!write_q) begin
                            rdata_q <= io_data_read;
                        end
                        if (HasHold) begin
                            state_q <= StHold;
                            cnt_q   <= HoldLoad;
                        end else begin
                            state_q <= StDone;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StHold: begin
                    if (phase_end) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (enter_done) begin
                io_ce               <= 1'b1;
                io_ub               <= 1'b1;
                io_lb               <= 1'b1;
                io_we               <= 1'b1;
                io_oe               <= 1'b1;
                io_data_writeEnable <= 1'b0;
                if (done_port_b) begin
                    b_rsp_valid <= 1'b1;
                    if (done_load_rdata) begin
                        b_rsp_rdata <= done_rdata;
                    end
                end else begin
                    a_rsp_valid <= 1'b1;
                    if (done_load_rdata) begin
                        a_rsp_rdata <= done_rdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl: reset, single write/read timing, arbitration,
// zero byte-enable and mid-command reset.
module tb_sram_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req_valid, a_req_ready, a_req_write;
    logic [15:0] a_req_addr, a_req_wdata;
    logic [1:0]  a_req_be;
    logic        a_rsp_valid;
    logic [15:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [15:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_be;
    logic        b_rsp_valid;
    logic [15:0] b_rsp_rdata;
    logic [15:0] io_address, io_data_read, io_data_write;
    logic        io_data_writeEnable, io_ce, io_we, io_oe, io_ub, io_lb;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sram_arbiter_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .a_req_valid         (a_req_valid),
        .a_req_ready         (a_req_ready),
        .a_req_write         (a_req_write),
        .a_req_addr          (a_req_addr),
        .a_req_wdata         (a_req_wdata),
        .a_req_be            (a_req_be),
        .a_rsp_valid         (a_rsp_valid),
        .a_rsp_rdata         (a_rsp_rdata),
        .b_req_valid         (b_req_valid),
        .b_req_ready         (b_req_ready),
        .b_req_write         (b_req_write),
        .b_req_addr          (b_req_addr),
        .b_req_wdata         (b_req_wdata),
        .b_req_be            (b_req_be),
        .b_rsp_valid         (b_rsp_valid),
        .b_rsp_rdata         (b_rsp_rdata),
        .io_address          (io_address),
        .io_data_read        (io_data_read),
        .io_data_write       (io_data_write),
        .io_data_writeEnable (io_data_writeEnable),
        .io_ce               (io_ce),
        .io_we               (io_we),
        .io_oe               (io_oe),
        .io_ub               (io_ub),
        .io_lb               (io_lb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        io_data_read = 16'h0000;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        tests_run++;
        if ({io_ce, io_we, io_oe, io_ub, io_lb} !== 5'b11111) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected 11111", {io_ce, io_we, io_oe, io_ub, io_lb});
        end
        tests_run++;
        if (io_data_writeEnable !== 1'b0 || io_address !== 16'h0 || io_data_write !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: got wen=%b addr=%h data=%h expected 0/0000/0000",
                     io_data_writeEnable, io_address, io_data_write);
        end
        tests_run++;
        if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_handshake: got %b expected 0000",
                     {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid});
        end
    endtask

    task automatic test_write_a;
        logic [6:1] exp_ce, exp_we, exp_wen, exp_rsp;
        exp_ce  = 6'b110000;
        exp_we  = 6'b111001;
        exp_wen = 6'b001111;
        exp_rsp = 6'b010000;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h1234;
        a_req_wdata = 16'hBEEF; a_req_be = 2'b11;
        #1;
        tests_run++;
        if (a_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_a_ready: got %b expected 1", a_req_ready);
        end
        tick();
        a_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tests_run++;
            if ({io_ce, io_we, io_oe, io_data_writeEnable, a_rsp_valid} !==
                {exp_ce[k], exp_we[k], 1'b1, exp_wen[k], exp_rsp[k]}) begin
                tests_failed++;
                $display("FAIL write_a_cycle%0d ce/we/oe/wen/rsp: got %b expected %b", k,
                         {io_ce, io_we, io_oe, io_data_writeEnable, a_rsp_valid},
                         {exp_ce[k], exp_we[k], 1'b1, exp_wen[k], exp_rsp[k]});
            end
            if (k == 4) begin
                tests_run++;
                if (io_address !== 16'h1234 || io_data_write !== 16'hBEEF) begin
                    tests_failed++;
                    $display("FAIL write_a_hold_bus: got addr=%h data=%h expected 1234/beef",
                             io_address, io_data_write);
                end
            end
            tick();
        end
    endtask

    task automatic test_read_b;
        logic [6:1] exp_oe, exp_lb, exp_rsp;
        exp_oe  = 6'b111001;
        exp_lb  = 6'b110000;
        exp_rsp = 6'b010000;
        io_data_read = 16'hDEAD;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'h1234;
        b_req_wdata = 16'h0000; b_req_be = 2'b01;
        #1;
        tests_run++;
        if ({a_req_ready, b_req_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL read_b_ready: got a=%b b=%b expected a=0 b=1", a_req_ready, b_req_ready);
        end
        tick();
        b_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            // Only the last ACCESS cycle presents the real data.
            io_data_read = (k == 3) ? 16'hBEEF : 16'hDEAD;
            tests_run++;
            if ({io_oe, io_we, io_ub, io_lb, io_data_writeEnable, b_rsp_valid, a_rsp_valid} !==
                {exp_oe[k], 1'b1, 1'b1, exp_lb[k], 1'b0, exp_rsp[k], 1'b0}) begin
                tests_failed++;
                $display("FAIL read_b_cycle%0d oe/we/ub/lb/wen/brsp/arsp: got %b expected %b", k,
                         {io_oe, io_we, io_ub, io_lb, io_data_writeEnable, b_rsp_valid, a_rsp_valid},
                         {exp_oe[k], 1'b1, 1'b1, exp_lb[k], 1'b0, exp_rsp[k], 1'b0});
            end
            if (k == 5) begin
                tests_run++;
                if (b_rsp_rdata !== 16'hBEEF) begin
                    tests_failed++;
                    $display("FAIL read_b_rdata: got %h expected beef", b_rsp_rdata);
                end
            end
            tick();
        end
        tests_run++;
        if (a_rsp_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL read_b_a_rdata_held: got %h expected 0000", a_rsp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int acc_cyc[8], rsp_cyc[8];
        bit acc_b[8], rsp_b[8];
        logic [15:0] rsp_data[8];
        int n_acc = 0;
        int n_rsp = 0;
        bit drop = 1'b0;
        io_data_read = 16'hCAFE;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 16'h0A0A; a_req_be = 2'b11;
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'h0B0B; b_req_be = 2'b11;
        for (int i = 0; i < 8; i++) begin
            acc_cyc[i] = -100; rsp_cyc[i] = -100; acc_b[i] = 1'b0; rsp_b[i] = 1'b0;
            rsp_data[i] = 16'h0;
        end
        #1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            drop = 1'b0;
            if (n_acc < 8 && ((a_req_valid && a_req_ready) || (b_req_valid && b_req_ready))) begin
                acc_cyc[n_acc] = cyc;
                acc_b[n_acc]   = b_req_valid && b_req_ready;
                n_acc++;
                drop = (n_acc == 4);
            end
            if (n_rsp < 8 && (a_rsp_valid || b_rsp_valid)) begin
                rsp_cyc[n_rsp]  = cyc;
                rsp_b[n_rsp]    = b_rsp_valid;
                rsp_data[n_rsp] = b_rsp_valid ? b_rsp_rdata : a_rsp_rdata;
                n_rsp++;
            end
            tick();
            if (drop) begin
                a_req_valid = 1'b0;
                b_req_valid = 1'b0;
            end
            #1;
        end
        tests_run++;
        if (n_acc != 4 || n_rsp != 4) begin
            tests_failed++;
            $display("FAIL b2b_counts: got accepts=%0d responses=%0d expected 4/4", n_acc, n_rsp);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (acc_b[i] !== i[0] || acc_cyc[i] != acc_cyc[0] + 6 * i) begin
                tests_failed++;
                $display("FAIL b2b_accept%0d: got port_b=%b cycle=%0d expected port_b=%b cycle=%0d",
                         i, acc_b[i], acc_cyc[i], i[0], acc_cyc[0] + 6 * i);
            end
            tests_run++;
            if (rsp_b[i] !== acc_b[i] || rsp_cyc[i] != acc_cyc[i] + 5 || rsp_data[i] !== 16'hCAFE) begin
                tests_failed++;
                $display("FAIL b2b_rsp%0d: got port_b=%b cycle=%0d data=%h expected port_b=%b cycle=%0d data=cafe",
                         i, rsp_b[i], rsp_cyc[i], rsp_data[i], acc_b[i], acc_cyc[i] + 5);
            end
        end
    endtask

    task automatic test_be_zero;
        bit saw_ce = 1'b0;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 16'h5555; a_req_be = 2'b00;
        #1;
        tests_run++;
        if (a_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL be0_ready: got %b expected 1", a_req_ready);
        end
        tick();
        a_req_valid = 1'b0;
        saw_ce = (io_ce !== 1'b1);
        tests_run++;
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL be0_rsp: got valid=%b rdata=%h expected 1/0000", a_rsp_valid, a_rsp_rdata);
        end
        tick();
        saw_ce = saw_ce || (io_ce !== 1'b1);
        tests_run++;
        if (a_rsp_valid !== 1'b0 || saw_ce) begin
            tests_failed++;
            $display("FAIL be0_after: got valid=%b ce_asserted=%b expected 0/0", a_rsp_valid, saw_ce);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_rsp = 1'b0;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h4321;
        a_req_wdata = 16'h1111; a_req_be = 2'b11;
        tick();
        a_req_valid = 1'b0;
        tick();
        tests_run++;
        if (io_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_access: got we=%b expected 0", io_we);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({io_we, io_ce, io_data_writeEnable} !== 3'b110 || io_address !== 16'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_pins: got we/ce/wen=%b addr=%h expected 110/0000",
                     {io_we, io_ce, io_data_writeEnable}, io_address);
        end
        for (int k = 0; k < 10; k++) begin
            saw_rsp = saw_rsp || a_rsp_valid || b_rsp_valid;
            tick();
        end
        tests_run++;
        if (saw_rsp) begin
            tests_failed++;
            $display("FAIL mid_reset_no_rsp: got response=1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_back_to_back();
        test_be_zero();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
- Shares one external 16-bit asynchronous SRAM between two requesters: port A (APB bridge side) and port B (DMA/stream side).
- Round-robin arbitration between the ports.
- Sequences SRAM timing as SETUP / ACCESS / HOLD phases with parameterised cycle counts.
- Drives the active-low SRAM pins and the tri-state data-bus enable.
- Sits between the APB RAM controller front end and the board-level SRAM pads.

Parameters:
- SETUP_CYCLES, 1, cycles with address/CE (and write data) valid before WE/OE asserts; legal 1..15.
- ACCESS_CYCLES, 2, cycles WE or OE held low; legal 1..15.
- HOLD_CYCLES, 1, cycles address/CE/data held after WE/OE release; legal 0..15.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- a_req_valid  in  1  port A command valid.
- a_req_ready  out  1  port A command accepted.
- a_req_write  in  1  1=write, 0=read.
- a_req_addr  in  16  word address.
- a_req_wdata  in  16  write data.
- a_req_be  in  2  byte enables, [1]=upper, [0]=lower.
- a_rsp_valid  out  1  one-cycle completion pulse.
- a_rsp_rdata  out  16  read data, valid with a_rsp_valid.
- b_req_valid, b_req_ready, b_req_write, b_req_addr, b_req_wdata, b_req_be, b_rsp_valid, b_rsp_rdata: same directions/widths as port A, for port B.
- io_address  out  16  SRAM address.
- io_data_read  in  16  SRAM data bus input.
- io_data_write  out  16  SRAM data bus output value.
- io_data_writeEnable  out  1  1=drive data bus.
- io_ce  out  1  chip enable, active low.
- io_we  out  1  write enable, active low.
- io_oe  out  1  output enable, active low.
- io_ub  out  1  upper byte select, active low.
- io_lb  out  1  lower byte select, active low.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port named reset.
- Reset values (all registered outputs, applied on the next edge):
  - io_ce=io_we=io_oe=io_ub=io_lb=1.
  - io_address=0, io_data_write=0, io_data_writeEnable=0.
  - rsp_valid=0, rsp_rdata=0 on both ports.
  - State=IDLE, last_grant=B.
- Reset mid-operation: the in-flight command is dropped and no rsp_valid is issued.
- States: IDLE, SETUP, ACCESS, HOLD, DONE. A 4-bit phase counter counts down within SETUP, ACCESS and HOLD.
- IDLE:
  - req_ready is combinational, asserted only in IDLE for the granted port.
  - Only one valid: grant that port.
  - Both valid: grant the port not equal to last_grant, then update last_grant.
  - On accept (valid&ready), register write, addr, wdata and be.
  - If be=00: go to DONE directly (no SRAM cycle; rsp_rdata=0). Otherwise go to SETUP.
- Requester protocol: hold valid and the command fields stable until ready. Dropping valid before ready is allowed (no effect).
- SETUP (SETUP_CYCLES cycles):
  - io_address=addr, io_ce=0, io_ub=~be[1], io_lb=~be[0].
  - Write: io_data_writeEnable=1, io_data_write=wdata.
  - Read: io_data_writeEnable=0.
- ACCESS (ACCESS_CYCLES cycles):
  - Write: io_we=0. Read: io_oe=0.
  - Read only: io_data_read is sampled into rdata at the clock edge ending the last ACCESS cycle.
- HOLD (HOLD_CYCLES cycles):
  - io_we=io_oe=1; io_ce, address, byte selects and write data/enable unchanged.
  - HOLD_CYCLES=0: HOLD is skipped, ACCESS goes straight to DONE.
- DONE (1 cycle):
  - io_ce=io_ub=io_lb=1, io_data_writeEnable=0.
  - Granted port rsp_valid=1 for exactly this cycle.
  - rsp_rdata = captured data on reads. On writes it is unchanged from its previous value (only meaningful for reads).
  - Next state IDLE.
- io_we and io_oe are never both low. io_data_writeEnable is never 1 while io_oe=0.
- Latency: rsp_valid asserts 1+SETUP+ACCESS+HOLD cycles after the accept cycle (default 5). Back-to-back throughput is one command per SETUP+ACCESS+HOLD+2 cycles (default 6).
- rsp_rdata of the non-granted port holds its value.

Test Plan:
- After reset, hold reset high for 3 cycles then release → all io_ strobes=1, writeEnable=0, both ready=0 until a valid arrives, both rsp_valid=0.
- Port A writes addr 0x1234, data 0xBEEF, be=11 (defaults) → timing:
  - SETUP: io_ce=0 with writeEnable=1 for 1 cycle.
  - ACCESS: io_we=0 for 2 cycles.
  - HOLD: 1 cycle with io_we=1 and data still driven.
  - a_rsp_valid pulses 5 cycles after accept.
- Port B reads addr 0x1234 with the SRAM model returning 0xBEEF, be=01 → io_oe=0 for 2 cycles, io_lb=0, io_ub=1, writeEnable=0 throughout; b_rsp_rdata=0xBEEF.
- Both ports valid continuously for 4 commands → grants alternate A,B,A,B; accepts are 6 cycles apart; each rsp_valid goes to the correct port.
- be=00 read on port A → no io_ce assertion; a_rsp_valid 1 cycle after accept with rdata=0.
- Reset asserted during ACCESS of a write → next edge: io_we=io_ce=1, writeEnable=0; no rsp_valid ever issued for that command.
